// File: rtl/req_fifo_1r1w_small_an_if.sv
// rtl/req_fifo_1r1w_small_an_if.sv - producer/consumer handshake bundle for the request FIFO
interface req_fifo_1r1w_small_an_if #(
  parameter int width_p = 32
) ();
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );
endinterface

// File: rtl/req_fifo_1r1w_small_an.sv
// rtl/req_fifo_1r1w_small_an.sv - small 1R1W request FIFO, valid/ready in, valid/yumi out
module req_fifo_1r1w_small_an #(
  parameter int width_p = 32,
  parameter int els_p   = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  req_fifo_1r1w_small_an_if.slave fifo_if
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [ptr_w_lp-1:0] last_idx_lp = ptr_w_lp'(els_p - 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic                last_enq_q, last_enq_d;
  logic                ptr_eq, full, empty, enq, deq;

  // Explicit wrap so depths that are not a power of two still cycle 0..els_p-1.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_idx_lp) ? '0 : p + 1'b1;
  endfunction

  assign ptr_eq = (rptr_q == wptr_q);
  assign full   = ptr_eq & last_enq_q;
  assign empty  = ptr_eq & ~last_enq_q;
  assign enq    = fifo_if.v_i & fifo_if.ready_o;
  assign deq    = fifo_if.yumi_i & ~empty;

  // Gating with reset keeps ready low while reset is held, not just after its edge.
  assign fifo_if.ready_o = ~full & reset_n_i;
  assign fifo_if.v_o     = ~empty;
  assign fifo_if.data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    last_enq_d = last_enq_q;
    if (enq) wptr_d = ptr_inc(wptr_q);
    if (deq) rptr_d = ptr_inc(rptr_q);
    if (enq & ~deq)      last_enq_d = 1'b1;
    else if (deq & ~enq) last_enq_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      last_enq_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      last_enq_q <= last_enq_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= fifo_if.data_i;
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fifo_if.yumi_i |-> fifo_if.v_o)
    else $error("yumi_i asserted while v_o low");
endmodule

// File: tb/tb_req_fifo_1r1w_small_an.sv
// tb/tb_req_fifo_1r1w_small_an.sv - randomized bench for the request FIFO at depths 4 and 5
module tb_req_fifo_1r1w_small_an;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  req_fifo_1r1w_small_an_if #(.width_p(32)) if0 ();
  req_fifo_1r1w_small_an_if #(.width_p(32)) if1 ();

  req_fifo_1r1w_small_an #(.width_p(32), .els_p(4)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .fifo_if(if0));
  req_fifo_1r1w_small_an #(.width_p(32), .els_p(5)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .fifo_if(if1));

  int n_checks = 0;
  int n_pass   = 0;
  int cap [2]  = '{4, 5};
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] drained [$];
  bit          v_s [2];
  bit          y_s [2];
  logic [31:0] d_s [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int msize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] mhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit mready(input int i);
    return rst_n && (msize(i) < cap[i]);
  endfunction

  function automatic bit mvalid(input int i);
    return msize(i) > 0;
  endfunction

  task automatic check_outs();
    check("ready0", {31'd0, if0.ready_o}, {31'd0, mready(0)});
    check("valid0", {31'd0, if0.v_o}, {31'd0, mvalid(0)});
    if (mvalid(0)) check("data0", if0.data_o, mhead(0));
    check("ready1", {31'd0, if1.ready_o}, {31'd0, mready(1)});
    check("valid1", {31'd0, if1.v_o}, {31'd0, mvalid(1)});
    if (mvalid(1)) check("data1", if1.data_o, mhead(1));
  endtask

  // Drive from a negedge, let the DUT act on the posedge, compare at the next negedge.
  task automatic step();
    bit e0, e1, dq0, dq1;
    if0.v_i = v_s[0]; if0.yumi_i = y_s[0]; if0.data_i = d_s[0];
    if1.v_i = v_s[1]; if1.yumi_i = y_s[1]; if1.data_i = d_s[1];
    e0 = v_s[0] && mready(0); dq0 = y_s[0] && mvalid(0);
    e1 = v_s[1] && mready(1); dq1 = y_s[1] && mvalid(1);
    @(posedge clk);
    if (dq0) void'(q0.pop_front());
    if (e0) q0.push_back(d_s[0]);
    if (dq1) void'(q1.pop_front());
    if (e1) q1.push_back(d_s[1]);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v_s[i] = 1'b0; y_s[i] = 1'b0; d_s[i] = '0;
    end
  endtask

  initial begin
    int k;
    idle_inputs();
    if0.v_i = 0; if0.yumi_i = 0; if0.data_i = 0;
    if1.v_i = 0; if1.yumi_i = 0; if1.data_i = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    repeat (10) step();
    rst_n = 1'b1;
    #1 check_outs();

    // single word
    v_s[0] = 1'b1; d_s[0] = 32'h1234;
    step();
    check("single_data", if0.data_o, 32'h1234);
    v_s[0] = 1'b0; y_s[0] = 1'b1;
    step();
    check("single_empty", {31'd0, if0.v_o}, 32'd0);
    y_s[0] = 1'b0;

    // fill depth-4 with 0..4, word 4 must wait
    k = 0; v_s[0] = 1'b1;
    repeat (6) begin
      bit acc;
      d_s[0] = k;
      acc = mready(0);
      step();
      if (acc) k++;
    end
    check("full_ready", {31'd0, if0.ready_o}, 32'd0);
    drained.push_back(if0.data_o);
    y_s[0] = 1'b1; d_s[0] = k;
    step();
    check("ready_after_deq", {31'd0, if0.ready_o}, 32'd1);
    y_s[0] = 1'b0;
    step();
    v_s[0] = 1'b0;
    y_s[0] = 1'b1;
    for (int n = 0; n < 8 && mvalid(0); n++) begin
      drained.push_back(if0.data_o);
      step();
    end
    y_s[0] = 1'b0;
    check("drain_len", drained.size(), 32'd5);
    for (int j = 0; j < drained.size() && j < 5; j++)
      check($sformatf("drain_%0d", j), drained[j], j);

    // depth-5 streaming across several wraps
    v_s[1] = 1'b1;
    for (int j = 0; j < 3; j++) begin d_s[1] = 32'hA0 + j; step(); end
    y_s[1] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      d_s[1] = 32'h100 + j;
      step();
      check("stream_v", {31'd0, if1.v_o}, 32'd1);
      check("stream_rdy", {31'd0, if1.ready_o}, 32'd1);
    end

    // full: enqueue+dequeue only dequeues
    y_s[1] = 1'b0;
    for (int n = 0; n < 8 && mready(1); n++) begin d_s[1] = 32'h200 + n; step(); end
    check("full1_ready", {31'd0, if1.ready_o}, 32'd0);
    d_s[1] = 32'hDEAD; y_s[1] = 1'b1;
    step();
    check("full1_after", {31'd0, if1.ready_o}, 32'd1);
    v_s[1] = 1'b0;
    for (int n = 0; n < 8 && msize(1) > 1; n++) step();
    v_s[1] = 1'b1; d_s[1] = 32'hBEEF;
    step();
    check("occ1_head", if1.data_o, 32'hBEEF);
    v_s[1] = 1'b0;
    step();
    y_s[1] = 1'b0;

    // mid-operation reset with three words stored
    v_s[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin d_s[0] = 32'h300 + j; step(); end
    v_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("rst_v0", {31'd0, if0.v_o}, 32'd0);
    check("rst_v1", {31'd0, if1.v_o}, 32'd0);
    check_outs();
    @(negedge clk);
    v_s[0] = 1'b1; d_s[0] = 32'h3FF;
    step();
    step();
    v_s[0] = 1'b0;
    rst_n = 1'b1;
    #1 check_outs();

    // random traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        v_s[i] = $urandom_range(0, 1);
        y_s[i] = mvalid(i) && ($urandom_range(0, 1) == 1);
        d_s[i] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
